fib_gen: RTL and testbench

//   Upstream producer for the display manager's 16-bit data input. Generates the Fibonacci

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_gen_bin2bcd.sv | 25 ++
 rtl/fib_gen.sv | 150 +++++++++++++++
 tb/tb_fib_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci term generator: FSM encoding, term width
// and the largest value a 4-digit BCD display can show.
package fib_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_RUN  = 2'd3
   } fib_state_e;

   localparam int unsigned      FIB_W   = 16;
   localparam logic [FIB_W-1:0] BCD_MAX = 16'd9999;

endpackage

// File: rtl/fib_gen_bin2bcd.sv
// Combinational double-dabble converter: 14-bit binary (0..9999) to 4 BCD digits.
module bin2bcd
   import fib_pkg::*;
(
   input  logic [13:0]      bin_i,
   output logic [FIB_W-1:0] bcd_o
);

   logic [29:0] sh;

   always_comb begin
      sh = {16'd0, bin_i};
      for (int i = 0; i < 14; i++) begin
         // Each digit column that would overflow past 9 on the next shift gets +3.
         for (int d = 0; d < 4; d++) begin
            if (sh[14+4*d +: 4] >= 4'd5) begin
               sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
            end
         end
         sh = sh << 1;
      end
      bcd_o = sh[29:14];
   end

endmodule

// File: rtl/fib_gen.sv
// Fibonacci term producer with valid/ready output, one term per slow tick.
// Define FIB_BCD_EN to present terms as 4-digit BCD (limit clamps to 9999).
module fib_gen
   import fib_pkg::*;
#(
   parameter logic [FIB_W-1:0] LIMIT           = 16'hFFFF,
   parameter bit               RESTART_ON_WRAP = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             tick,
   input  logic             data_ready,
   output logic [FIB_W-1:0] data_out,
   output logic             data_valid,
   output logic [4:0]       idx,
   output logic             wrap,
   output logic             done,
   output logic             ovr
);

`ifdef FIB_BCD_EN
   localparam logic [FIB_W:0] EFF_LIMIT = (LIMIT > BCD_MAX) ? {1'b0, BCD_MAX} : {1'b0, LIMIT};
`else
   localparam logic [FIB_W:0] EFF_LIMIT = {1'b0, LIMIT};
`endif

   fib_state_e       state_q, state_d;
   logic [FIB_W:0]   a_q, a_d, b_q, b_d;
   logic [FIB_W-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic [4:0]       idx_q, idx_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
   logic             ovr_q, ovr_d;
   logic [FIB_W-1:0] term_fmt;

`ifdef FIB_BCD_EN
   bin2bcd u_bin2bcd (
      .bin_i (b_q[13:0]),
      .bcd_o (term_fmt)
   );
`else
   assign term_fmt = b_q[FIB_W-1:0];
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      done_d  = done_q;
      ovr_d   = ovr_q;

      // A tick while a term is still unconsumed is lost, never queued.
      if (tick && valid_q) ovr_d = 1'b1;

      if (stop) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               valid_d = 1'b0;
               if (start) begin
                  state_d = ST_LOAD;
                  done_d  = 1'b0;
                  ovr_d   = 1'b0;
               end
            end
            ST_LOAD: begin
               a_d     = '0;
               b_d     = {{FIB_W{1'b0}}, 1'b1};
               dout_d  = '0;
               idx_d   = '0;
               valid_d = 1'b1;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               valid_d = 1'b1;
               if (valid_q && data_ready) begin
                  valid_d = 1'b0;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               valid_d = 1'b0;
               if (tick) begin
                  if (b_q <= EFF_LIMIT) begin
                     dout_d  = term_fmt;
                     idx_d   = idx_q + 5'd1;
                     a_d     = b_q;
                     b_d     = a_q + b_q;
                     valid_d = 1'b1;
                     state_d = ST_WAIT;
                  end else if (RESTART_ON_WRAP) begin
                     dout_d  = '0;
                     idx_d   = '0;
                     a_d     = '0;
                     b_d     = {{FIB_W{1'b0}}, 1'b1};
                     wrap_d  = 1'b1;
                     valid_d = 1'b1;
                     state_d = ST_WAIT;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign idx        = idx_q;
   assign wrap       = wrap_q;
   assign done       = done_q;
   assign ovr        = ovr_q;

endmodule

// File: tb/tb_fib_gen.sv
// Bench for fib_gen: scoreboarded term stream plus a table of known Fibonacci values.
module tb_fib_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, stop = 1'b0, tick = 1'b0, data_ready = 1'b0;
   logic [15:0] data_out, data_out2;
   logic        data_valid, data_valid2;
   logic [4:0]  idx, idx2;
   logic        wrap, wrap2, done, done2, ovr, ovr2;

   always #5 clk = ~clk;

   fib_gen u_dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick),
      .data_ready(data_ready), .data_out(data_out), .data_valid(data_valid),
      .idx(idx), .wrap(wrap), .done(done), .ovr(ovr)
   );

   fib_gen #(.RESTART_ON_WRAP(1'b0)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .tick(tick),
      .data_ready(data_ready), .data_out(data_out2), .data_valid(data_valid2),
      .idx(idx2), .wrap(wrap2), .done(done2), .ovr(ovr2)
   );

`ifdef FIB_BCD_EN
   localparam int unsigned LIM = 9999;
`else
   localparam int unsigned LIM = 65535;
`endif

   int n_cmp = 0;
   int n_fail = 0;
   int xfer_cnt = 0;
   int wrap_cnt = 0;
   logic [21:0] exp_q[$];
   logic [15:0] cap[0:31];

   int unsigned m_a, m_b;
   int          m_n;
   bit          m_wrapped;

   typedef struct {
      int          n;
      logic [15:0] bin_v;
      logic [15:0] bcd_v;
      bit          in_bcd;
   } vec_t;
   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] fmt(input int unsigned v);
`ifdef FIB_BCD_EN
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
      logic [31:0] t;
      t = v;
      return t[15:0];
`endif
   endfunction

   // Scoreboard: every accepted term must match the oldest expectation.
   always @(negedge clk) begin
      if (rst) begin
         if (wrap) wrap_cnt++;
         if (data_valid && data_ready) begin
            xfer_cnt++;
            cap[idx] = data_out;
            if (exp_q.size() == 0) chk("queue_nonempty", 32'(exp_q.size()), 32'd1);
            else chk("term", 32'({wrap, idx, data_out}), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic wait_xfer(input int c0);
      for (int i = 0; i < 40 && xfer_cnt == c0; i++) @(posedge clk);
      chk("xfer_seen", 32'(xfer_cnt - c0), 32'd1);
   endtask

   task automatic pulse(input int which);
      @(posedge clk); #1;
      if (which == 0) start = 1'b1;
      if (which == 1) stop = 1'b1;
      if (which == 2) tick = 1'b1;
      if (which == 3) begin start = 1'b1; stop = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; tick = 1'b0;
   endtask

   task automatic do_start(input bit wait_x);
      int c0;
      m_a = 0; m_b = 1; m_n = 0; m_wrapped = 0;
      exp_q.push_back({1'b0, 5'd0, 16'd0});
      c0 = xfer_cnt;
      pulse(0);
      if (wait_x) wait_xfer(c0);
   endtask

   task automatic tick_expect(input bit wait_x);
      int c0;
      int unsigned t;
      logic wr;
      wr = 1'b0;
      if (m_b > LIM) begin
         m_a = 0; m_b = 1; m_n = 0; wr = 1'b1; m_wrapped = 1;
      end else begin
         t = m_a + m_b; m_a = m_b; m_b = t; m_n++;
      end
      exp_q.push_back({wr, 5'(m_n), fmt(m_a)});
      c0 = xfer_cnt;
      pulse(2);
      if (wait_x) wait_xfer(c0);
   endtask

   initial begin
      vecs[0]  = '{0,  16'h0000, 16'h0000, 1'b1};
      vecs[1]  = '{1,  16'h0001, 16'h0001, 1'b1};
      vecs[2]  = '{2,  16'h0001, 16'h0001, 1'b1};
      vecs[3]  = '{3,  16'h0002, 16'h0002, 1'b1};
      vecs[4]  = '{4,  16'h0003, 16'h0003, 1'b1};
      vecs[5]  = '{5,  16'h0005, 16'h0005, 1'b1};
      vecs[6]  = '{6,  16'h0008, 16'h0008, 1'b1};
      vecs[7]  = '{7,  16'h000D, 16'h0013, 1'b1};
      vecs[8]  = '{12, 16'h0090, 16'h0144, 1'b1};
      vecs[9]  = '{20, 16'h1A6D, 16'h6765, 1'b1};
      vecs[10] = '{24, 16'hB520, 16'hB520, 1'b0};
      for (int i = 0; i < 32; i++) cap[i] = 16'hDEAD;

      // Reset state
      #12;
      chk("reset_outputs", 32'({data_out, data_valid, idx, wrap, done, ovr}), 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Async reset in the middle of WAIT, with ovr already set
      do_start(1'b0);
      repeat (3) @(posedge clk);
      pulse(2);
      chk("wait_valid", 32'(data_valid), 32'd1);
      chk("wait_ovr", 32'(ovr), 32'd1);
      @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("async_reset", 32'({data_valid, ovr, wrap, done}), 32'd0);
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_after_reset", 32'(data_valid), 32'd0);

      // Normal run, ready high, tick every 8 clocks
      data_ready = 1'b1;
      do_start(1'b1);
      @(negedge clk);
      chk("valid_one_cycle", 32'(data_valid), 32'd0);
      for (int k = 1; k < 8; k++) begin
         repeat (8) @(posedge clk);
         tick_expect(1'b1);
      end

      // Backpressure: restart, hold ready low, three dropped ticks
      pulse(1);
      data_ready = 1'b0;
      do_start(1'b0);
      for (int k = 0; k < 3; k++) begin
         repeat (3) @(posedge clk);
         pulse(2);
      end
      @(negedge clk);
      chk("bp_hold", 32'({data_valid, data_out}), 32'h10000);
      chk("bp_ovr", 32'(ovr), 32'd1);
      begin
         int c0;
         c0 = xfer_cnt;
         data_ready = 1'b1;
         wait_xfer(c0);
      end
      tick_expect(1'b1);

      // Run to the wrap point
      wrap_cnt = 0;
      while (!m_wrapped) begin
         repeat (2) @(posedge clk);
         tick_expect(1'b1);
      end
      @(negedge clk);
      chk("wrap_once", 32'(wrap_cnt), 32'd1);
      chk("norestart_done", 32'({done2, data_valid2}), 32'h2);
      tick_expect(1'b1);
      chk("norestart_idle", 32'({done2, data_valid2}), 32'h2);

      // Known terms captured during the run
      foreach (vecs[i]) begin
`ifdef FIB_BCD_EN
         if (vecs[i].in_bcd) chk($sformatf("F%0d", vecs[i].n), 32'(cap[vecs[i].n]), 32'(vecs[i].bcd_v));
`else
         chk($sformatf("F%0d", vecs[i].n), 32'(cap[vecs[i].n]), 32'(vecs[i].bin_v));
`endif
      end

      // stop while a term is pending, then start&stop together in IDLE
      data_ready = 1'b0;
      tick_expect(1'b0);
      repeat (2) @(negedge clk);
      chk("pending_valid", 32'(data_valid), 32'd1);
      pulse(1);
      void'(exp_q.pop_back());
      @(negedge clk);
      chk("stop_drops_valid", 32'(data_valid), 32'd0);
      pulse(3);
      repeat (4) @(negedge clk);
      chk("start_stop_idle", 32'(data_valid), 32'd0);
      data_ready = 1'b1;
      do_start(1'b1);
      chk("start_clears_ovr", 32'(ovr), 32'd0);
      chk("start_clears_done", 32'(done2), 32'd0);
      repeat (4) @(posedge clk);
      tick_expect(1'b1);

      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
